// File: rtl/axi_addr_remap.sv
// AXI4 address remapper: window-matched AW/AR addresses are rewritten and forwarded through
// one-entry output registers; misses are absorbed locally and answered with DECERR responses.
module axi_addr_remap #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned NUM_WIN    = 2,
  parameter logic [NUM_WIN*ADDR_WIDTH-1:0] WIN_BASE = {32'h8000_0000, 32'h0},
  parameter logic [NUM_WIN*ADDR_WIDTH-1:0] WIN_MASK = {32'hF000_0000, 32'hF000_0000},
  parameter logic [NUM_WIN*ADDR_WIDTH-1:0] WIN_TGT  = {32'h1000_0000, 32'h1000_0000},
  parameter int unsigned OUTST_W    = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int unsigned AXW = ADDR_WIDTH + ID_WIDTH + 25;
  localparam logic [OUTST_W-1:0] OUT_MAX = '1;

  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_ERR} r_state_e;

  // Returns {hit, remapped address}; scanning downward lets the lowest index win.
  function automatic logic [ADDR_WIDTH:0] win_lookup(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0]   r;
    logic [ADDR_WIDTH-1:0] b, m, t;
    r = {1'b0, a};
    for (int unsigned i = NUM_WIN; i > 0; i--) begin
      b = WIN_BASE[(i-1)*ADDR_WIDTH +: ADDR_WIDTH];
      m = WIN_MASK[(i-1)*ADDR_WIDTH +: ADDR_WIDTH];
      t = WIN_TGT[(i-1)*ADDR_WIDTH +: ADDR_WIDTH];
      if ((a & m) == (b & m)) r = {1'b1, (a & ~m) | (t & m)};
    end
    return r;
  endfunction

  w_state_e            w_state_q;
  r_state_e            r_state_q;
  logic                awvalid_q, arvalid_q;
  logic [AXW-1:0]      aw_pl_q, ar_pl_q;
  logic [OUTST_W-1:0]  wr_out_q, wr_out_d, rd_out_q, rd_out_d;
  logic [ID_WIDTH-1:0] bid_q, rid_q;
  logic [7:0]          rlen_q, rbeat_q;

  logic [ADDR_WIDTH:0] aw_lk, ar_lk;
  logic aw_hit, ar_hit, aw_acc, ar_acc, aw_fwd, ar_fwd, b_ret, r_ret;

  assign aw_lk  = win_lookup(s_axi_awaddr);
  assign ar_lk  = win_lookup(s_axi_araddr);
  assign aw_hit = aw_lk[ADDR_WIDTH];
  assign ar_hit = ar_lk[ADDR_WIDTH];

  // Counters increment at upstream acceptance, so a zero count also means the output register is empty.
  assign s_axi_awready = (w_state_q == W_IDLE) &&
                         (aw_hit ? ((!awvalid_q || m_axi_awready) && (wr_out_q != OUT_MAX))
                                 : (wr_out_q == '0));
  assign s_axi_arready = (r_state_q == R_IDLE) &&
                         (ar_hit ? ((!arvalid_q || m_axi_arready) && (rd_out_q != OUT_MAX))
                                 : (rd_out_q == '0));

  assign aw_acc = s_axi_awvalid && s_axi_awready;
  assign ar_acc = s_axi_arvalid && s_axi_arready;
  assign aw_fwd = aw_acc && aw_hit;
  assign ar_fwd = ar_acc && ar_hit;
  assign b_ret  = m_axi_bvalid && m_axi_bready;
  assign r_ret  = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_arvalid = arvalid_q;
  assign {m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst,
          m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos} = aw_pl_q;
  assign {m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
          m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos} = ar_pl_q;

  assign m_axi_wdata  = s_axi_wdata;
  assign m_axi_wstrb  = s_axi_wstrb;
  assign m_axi_wlast  = s_axi_wlast;
  assign m_axi_wvalid = s_axi_wvalid && (w_state_q != W_DRAIN);
  assign s_axi_wready = (w_state_q == W_DRAIN) ? 1'b1 : m_axi_wready;

  assign s_axi_bvalid = (w_state_q == W_RESP) ? 1'b1   : m_axi_bvalid;
  assign s_axi_bresp  = (w_state_q == W_RESP) ? 2'b11  : m_axi_bresp;
  assign s_axi_bid    = (w_state_q == W_RESP) ? bid_q  : m_axi_bid;
  assign m_axi_bready = (w_state_q == W_RESP) ? 1'b0   : s_axi_bready;

  assign s_axi_rvalid = (r_state_q == R_ERR) ? 1'b1                : m_axi_rvalid;
  assign s_axi_rresp  = (r_state_q == R_ERR) ? 2'b11               : m_axi_rresp;
  assign s_axi_rid    = (r_state_q == R_ERR) ? rid_q               : m_axi_rid;
  assign s_axi_rdata  = (r_state_q == R_ERR) ? '0                  : m_axi_rdata;
  assign s_axi_rlast  = (r_state_q == R_ERR) ? (rbeat_q == rlen_q) : m_axi_rlast;
  assign m_axi_rready = (r_state_q == R_ERR) ? 1'b0                : s_axi_rready;

  always_comb begin
    wr_out_d = wr_out_q;
    rd_out_d = rd_out_q;
    if (aw_fwd && !b_ret) wr_out_d = wr_out_q + 1'b1;
    if (!aw_fwd && b_ret) wr_out_d = wr_out_q - 1'b1;
    if (ar_fwd && !r_ret) rd_out_d = rd_out_q + 1'b1;
    if (!ar_fwd && r_ret) rd_out_d = rd_out_q - 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      aw_pl_q   <= '0;
      ar_pl_q   <= '0;
      wr_out_q  <= '0;
      rd_out_q  <= '0;
      bid_q     <= '0;
      rid_q     <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
    end else begin
      wr_out_q <= wr_out_d;
      rd_out_q <= rd_out_d;

      if (aw_fwd) begin
        awvalid_q <= 1'b1;
        aw_pl_q   <= {aw_lk[ADDR_WIDTH-1:0], s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                      s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos};
      end else if (m_axi_awready) begin
        awvalid_q <= 1'b0;
      end

      if (ar_fwd) begin
        arvalid_q <= 1'b1;
        ar_pl_q   <= {ar_lk[ADDR_WIDTH-1:0], s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                      s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};
      end else if (m_axi_arready) begin
        arvalid_q <= 1'b0;
      end

      unique case (w_state_q)
        W_IDLE:  if (aw_acc && !aw_hit) begin
                   bid_q     <= s_axi_awid;
                   w_state_q <= W_DRAIN;
                 end
        W_DRAIN: if (s_axi_wvalid && s_axi_wlast) w_state_q <= W_RESP;
        W_RESP:  if (s_axi_bready) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase

      unique case (r_state_q)
        R_IDLE: if (ar_acc && !ar_hit) begin
                  rid_q     <= s_axi_arid;
                  rlen_q    <= s_axi_arlen;
                  rbeat_q   <= '0;
                  r_state_q <= R_ERR;
                end
        R_ERR:  if (s_axi_rready) begin
                  if (rbeat_q == rlen_q) r_state_q <= R_IDLE;
                  else rbeat_q <= rbeat_q + 8'd1;
                end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_addr_remap.sv
// Directed bench for axi_addr_remap with default windows (0x0xxx_xxxx and 0x8xxx_xxxx -> 0x1xxx_xxxx).
module tb_axi_addr_remap;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_axi_awaddr, s_axi_araddr, m_axi_awaddr, m_axi_araddr;
  logic        s_axi_awid, s_axi_arid, m_axi_awid, m_axi_arid;
  logic [7:0]  s_axi_awlen, s_axi_arlen, m_axi_awlen, m_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize, m_axi_awsize, m_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, m_axi_awburst, m_axi_arburst;
  logic        s_axi_awlock, s_axi_arlock, m_axi_awlock, m_axi_arlock;
  logic [3:0]  s_axi_awcache, s_axi_arcache, m_axi_awcache, m_axi_arcache;
  logic [2:0]  s_axi_awprot, s_axi_arprot, m_axi_awprot, m_axi_arprot;
  logic [3:0]  s_axi_awqos, s_axi_arqos, m_axi_awqos, m_axi_arqos;
  logic        s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
  logic        s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
  logic [63:0] s_axi_wdata, m_axi_wdata, s_axi_rdata, m_axi_rdata;
  logic [7:0]  s_axi_wstrb, m_axi_wstrb;
  logic        s_axi_wlast, s_axi_wvalid, s_axi_wready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        s_axi_bid, m_axi_bid, s_axi_rid, m_axi_rid;
  logic [1:0]  s_axi_bresp, m_axi_bresp, s_axi_rresp, m_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready, m_axi_rlast, m_axi_rvalid, m_axi_rready;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  always #5 aclk = ~aclk;

  axi_addr_remap #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(1), .NUM_WIN(2), .OUTST_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge aclk);
  endtask

  initial begin
    int unsigned sent, recv, beat;
    aresetn = 1'b0;
    {s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
     s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awvalid} = '0;
    {s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock,
     s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid} = '0;
    {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready, s_axi_rready} = '0;
    {m_axi_awready, m_axi_arready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid} = '0;
    {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid} = '0;

    step(); step(); #1;
    chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst_bvalid",  64'(s_axi_bvalid),  64'd0);
    chk("rst_rvalid",  64'(s_axi_rvalid),  64'd0);
    step(); aresetn = 1'b1;

    // Read hit on window 1, every sideband field must come through untouched
    step();
    m_axi_arready = 1'b1;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h8000_1234; s_axi_arid = 1'b1; s_axi_arlen = 8'd5;
    s_axi_arsize = 3'd3; s_axi_arburst = 2'd1; s_axi_arlock = 1'b1; s_axi_arcache = 4'h3;
    s_axi_arprot = 3'h2; s_axi_arqos = 4'h7;
    #1 chk("ar_hit_ready", 64'(s_axi_arready), 64'd1);
    chk("ar_pre_valid", 64'(m_axi_arvalid), 64'd0);
    step(); s_axi_arvalid = 1'b0;
    #1 chk("ar_hit_valid", 64'(m_axi_arvalid), 64'd1);
    chk("ar_hit_addr", 64'(m_axi_araddr), 64'h1000_1234);
    chk("ar_hit_fields", 64'({m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                              m_axi_arcache, m_axi_arprot, m_axi_arqos}),
        64'({1'b1, 8'd5, 3'd3, 2'd1, 1'b1, 4'h3, 3'h2, 4'h7}));
    step();
    m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rid = 1'b1; m_axi_rdata = 64'hDEAD_BEEF_0123_4567;
    m_axi_rresp = 2'b00; s_axi_rready = 1'b1;
    #1 chk("ar_drop_valid", 64'(m_axi_arvalid), 64'd0);
    chk("r_pass_valid", 64'(s_axi_rvalid), 64'd1);
    chk("r_pass_data", s_axi_rdata, 64'hDEAD_BEEF_0123_4567);
    chk("r_pass_ready", 64'(m_axi_rready), 64'd1);
    step(); m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s_axi_rready = 1'b0;

    // W passes through while idle
    s_axi_wvalid = 1'b1; s_axi_wdata = 64'h55; m_axi_wready = 1'b0;
    #1 chk("w_pass_valid", 64'(m_axi_wvalid), 64'd1);
    chk("w_pass_ready", 64'(s_axi_wready), 64'd0);
    step(); s_axi_wvalid = 1'b0;

    // Write hits on window 0 under backpressure
    m_axi_awready = 1'b0;
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0ABC_0000; s_axi_awid = 1'b0; s_axi_awlen = 8'd3;
    #1 chk("aw1_ready", 64'(s_axi_awready), 64'd1);
    step(); s_axi_awaddr = 32'h0000_0010; s_axi_awid = 1'b1; s_axi_awlen = 8'd0;
    #1 chk("aw1_addr", 64'(m_axi_awaddr), 64'h1ABC_0000);
    chk("aw1_len", 64'(m_axi_awlen), 64'd3);
    chk("aw_full_stall", 64'(s_axi_awready), 64'd0);
    step();
    #1 chk("aw1_hold_valid", 64'(m_axi_awvalid), 64'd1);
    chk("aw1_hold_addr", 64'(m_axi_awaddr), 64'h1ABC_0000);
    step(); m_axi_awready = 1'b1;
    #1 chk("aw_thru_ready", 64'(s_axi_awready), 64'd1);
    step(); s_axi_awvalid = 1'b0;
    #1 chk("aw2_addr", 64'(m_axi_awaddr), 64'h1000_0010);
    chk("aw2_id", 64'(m_axi_awid), 64'd1);

    // Write miss must wait for both outstanding B responses
    step();
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h4000_0000; s_axi_awid = 1'b1; s_axi_awlen = 8'd3;
    #1 chk("aw_miss_nofwd", 64'(m_axi_awvalid), 64'd0);
    chk("aw_miss_stall2", 64'(s_axi_awready), 64'd0);
    step(); m_axi_bvalid = 1'b1; m_axi_bid = 1'b0; m_axi_bresp = 2'b00; s_axi_bready = 1'b1;
    #1 chk("b_pass_valid", 64'(s_axi_bvalid), 64'd1);
    chk("b_pass_ready", 64'(m_axi_bready), 64'd1);
    step(); m_axi_bid = 1'b1;
    #1 chk("aw_miss_stall1", 64'(s_axi_awready), 64'd0);
    chk("b_pass_id", 64'(s_axi_bid), 64'd1);
    step(); m_axi_bvalid = 1'b0; s_axi_bready = 1'b0;
    #1 chk("aw_miss_accept", 64'(s_axi_awready), 64'd1);
    step(); s_axi_awvalid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      s_axi_wvalid = 1'b1; s_axi_wlast = (i == 3); m_axi_wready = 1'b1;
      #1 chk("drain_wready", 64'(s_axi_wready), 64'd1);
      chk("drain_m_wvalid", 64'(m_axi_wvalid), 64'd0);
      if (i == 1) chk("rd_indep_of_wr", 64'(s_axi_arready), 64'd1);
      step();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    s_axi_awaddr = 32'h8000_0000;
    #1 chk("err_bvalid", 64'(s_axi_bvalid), 64'd1);
    chk("err_bresp", 64'(s_axi_bresp), 64'd3);
    chk("err_bid", 64'(s_axi_bid), 64'd1);
    chk("err_m_bready", 64'(m_axi_bready), 64'd0);
    chk("resp_no_aw", 64'(s_axi_awready), 64'd0);
    step(); s_axi_bready = 1'b1;
    #1 chk("err_bhold", 64'(s_axi_bvalid), 64'd1);
    step(); s_axi_bready = 1'b0;
    #1 chk("err_bdone", 64'(s_axi_bvalid), 64'd0);

    // Read miss, len 7, rready toggling every cycle
    step();
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h4000_0000; s_axi_arid = 1'b1; s_axi_arlen = 8'd7;
    #1 chk("ar_miss_accept", 64'(s_axi_arready), 64'd1);
    step(); s_axi_arvalid = 1'b0;
    beat = 0;
    for (int c = 0; c < 40 && beat < 8; c++) begin
      s_axi_rready = c[0];
      #1 chk("rerr_valid", 64'(s_axi_rvalid), 64'd1);
      chk("rerr_resp", 64'(s_axi_rresp), 64'd3);
      chk("rerr_id", 64'(s_axi_rid), 64'd1);
      chk("rerr_data", s_axi_rdata, 64'd0);
      chk("rerr_last", 64'(s_axi_rlast), 64'(beat == 7));
      if (c == 2) begin
        chk("rerr_no_ar", 64'(s_axi_arready), 64'd0);
        chk("wr_indep_of_rd", 64'(s_axi_awready), 64'd1);
      end
      if (s_axi_rready) beat++;
      step();
    end
    chk("rerr_beats", 64'(beat), 64'd8);
    s_axi_rready = 1'b0;
    #1 chk("rerr_done", 64'(s_axi_rvalid), 64'd0);

    // 16 read hits against a stalled master; the 16th must wait for a returned R
    sent = 0; recv = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      m_axi_arready = (c >= 20);
      s_axi_arvalid = (sent < 16); s_axi_araddr = 32'h8000_0000 + sent; s_axi_arid = 1'b0;
      s_axi_arlen = 8'd0;
      #1;
      if (m_axi_arvalid) begin
        chk("stall_araddr", 64'(m_axi_araddr), 64'h1000_0000 + 64'(recv));
        if (m_axi_arready) recv++;
      end
      if (s_axi_arvalid && s_axi_arready) sent++;
    end
    chk("stall_sent15", 64'(sent), 64'd15);
    chk("stall_recv15", 64'(recv), 64'd15);
    chk("stall_at_max", 64'(s_axi_arready), 64'd0);
    step(); m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; s_axi_rready = 1'b1;
    #1 chk("stall_still", 64'(s_axi_arready), 64'd0);
    step(); m_axi_rvalid = 1'b0;
    #1 chk("stall_release", 64'(s_axi_arready), 64'd1);
    step(); s_axi_arvalid = 1'b0;
    #1 chk("last_ar_valid", 64'(m_axi_arvalid), 64'd1);
    chk("last_ar_addr", 64'(m_axi_araddr), 64'h1000_000F);
    for (int i = 0; i < 15; i++) begin
      step(); m_axi_rvalid = 1'b1;
    end
    step(); m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    #1 chk("rd_drained", 64'(m_axi_arvalid), 64'd0);

    // Reset during beat 3 of an error burst
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h4000_0000; s_axi_arid = 1'b1; s_axi_arlen = 8'd7;
    #1 chk("ar_miss2_accept", 64'(s_axi_arready), 64'd1);
    step(); s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    step(); step(); step();
    #1 chk("beat3_valid", 64'(s_axi_rvalid), 64'd1);
    chk("beat3_last", 64'(s_axi_rlast), 64'd0);
    aresetn = 1'b0;
    #1 chk("rst_kills_rvalid", 64'(s_axi_rvalid), 64'd0);
    step(); aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      #1 chk("post_rst_quiet", 64'(s_axi_rvalid), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/axi_addr_remap.md
AXI_ADDR_REMAP -- requirements
Module: axi_addr_remap

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width on both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data width on both ports.
REQ-003 SHALL have parameter ID_WIDTH, default 1, ID width on both ports.
REQ-004 SHALL have parameter NUM_WIN, default 2, number of remap windows.
REQ-005 SHALL have parameter WIN_BASE, default {32'h8000_0000, 32'h0}, NUM_WIN×ADDR_WIDTH match bases.
REQ-006 SHALL have parameter WIN_MASK, default {32'hF000_0000, 32'hF000_0000}, NUM_WIN×ADDR_WIDTH match/replace masks.
REQ-007 SHALL have parameter WIN_TGT, default {32'h1000_0000, 32'h1000_0000}, NUM_WIN×ADDR_WIDTH replacement bits.
REQ-008 SHALL have parameter OUTST_W, default 4, width of the outstanding-transaction counters.
REQ-009 SHALL have port aclk, input, 1, sole clock; all logic on its rising edge.
REQ-010 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-011 SHALL have s_axi_aw*/ar*, input, full AXI4 AW/AR (addr ADDR_WIDTH, id ID_WIDTH, len 8, size 3, burst 2, lock 1, cache 4, prot 3, qos 4), ready output.
REQ-012 SHALL have s_axi_w*, input, wdata DATA_WIDTH, wstrb DATA_WIDTH/8, wlast, wvalid; wready output.
REQ-013 SHALL have s_axi_b*/r*, output, bid/rid ID_WIDTH, bresp/rresp 2, rdata DATA_WIDTH, rlast, valid; ready inputs.
REQ-014 SHALL have m_axi_*, mirror of s_axi_* with directions reversed.

Function
REQ-015 Window match: window i SHALL hit when (addr & WIN_MASK[i]) == (WIN_BASE[i] & WIN_MASK[i]); lowest index wins.
REQ-016 Remap: out addr SHALL be (addr & ~WIN_MASK[i]) | (WIN_TGT[i] & WIN_MASK[i]); all other AW/AR fields unchanged.
REQ-017 AW and AR SHALL each pass through a one-entry output register: 1-cycle latency; s ready = !full || m ready; full throughput.
REQ-018 Registered m valid SHALL hold with payload stable until m ready (no drop, no change under backpressure).
REQ-019 Counters wr_out (AW forwarded, B not returned) and rd_out (AR forwarded, last R not returned) SHALL inc/dec per handshake; simultaneous inc+dec leaves value.
REQ-020 Forwarding SHALL stall (s ready=0) when the respective counter equals 2^OUTST_W-1.
REQ-021 Miss on AW: SHALL stall until wr_out==0, then accept AW and enter W_DRAIN.
REQ-022 W_DRAIN: s_axi_wready=1, m_axi_wvalid=0, beats discarded; on wlast -> W_RESP.
REQ-023 W_RESP: bvalid=1, bresp=2'b11, bid=captured awid; on bready -> W_IDLE; no new AW accepted outside W_IDLE.
REQ-024 Outside W_DRAIN, W and B channels SHALL pass through combinationally.
REQ-025 Miss on AR: SHALL stall until rd_out==0, then accept AR and enter R_ERR.
REQ-026 R_ERR: emit arlen+1 beats, rresp=2'b11, rdata=0, rid=captured arid, rlast on final beat; beat counter advances only on rready; after last -> R_IDLE.
REQ-027 Outside R_ERR, R channel SHALL pass through combinationally; no AR accepted in R_ERR.
REQ-028 AW path and AR path SHALL be independent; a read error SHALL NOT stall writes and vice versa.

Reset
REQ-029 aresetn low SHALL asynchronously clear registers: m_axi_awvalid/arvalid=0, counters=0, FSMs to W_IDLE/R_IDLE, local bvalid/rvalid=0.
REQ-030 Reset mid-burst SHALL abandon any error burst; no response emitted after deassertion.
REQ-031 Outputs SHALL be stable within one aclk after synchronous aresetn deassertion; s ready may assert in first cycle.

Verification
REQ-032 AR 0x8000_1234, window 1 default -> m_axi_araddr 0x1000_1234 one cycle later, all fields equal.
REQ-033 AW 0x4000_0000 (miss), len=3, 4 W beats -> wready each beat, m_axi_wvalid never 1, one B bresp=2'b11 with awid.
REQ-034 AR miss len=7 with rready toggling 50% -> 8 beats rresp=2'b11, rlast only on 8th, rid correct.
REQ-035 m_axi_arready=0 for 20 cycles, 16 hits issued -> m arvalid held, payload stable, stall at rd_out=15, none lost.
REQ-036 AW miss while wr_out=2 -> AW stalled until both B returned, then error burst proceeds.
REQ-037 aresetn pulsed low in R_ERR beat 3 -> rvalid=0 immediately; no further beats after release.
